pll_dpa_ctrl: RTL and testbench
===============================

Name: pll_dpa_ctrl

Overview:
Runtime controller for the dynamic-phase/duty/fine-delay inputs of the DDR PLL wrapper (psda, dutyda, fdly) and consumer of its lock output. It accepts phase-setting requests from DDR3 read-capture calibration and walks psda to the target one step at a time. After each step it waits a settle interval, then confirms that lock is stable before stepping again. It reports completion or a lock-loss timeout to the requester via a valid/ready-style handshake.

Parameters:
SETTLE_CYCLES, 16, clkin cycles held after every output change before lock is sampled (>=1)
LOCK_STABLE, 8, consecutive cycles of synchronized lock required to accept a step (>=1)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before error abort (>LOCK_STABLE)
PSDA_INIT, 4'h0, psda value after reset
DUTY_INIT, 4'h8, dutyda value after reset
FDLY_INIT, 4'h0, fdly value after reset

Ports:
clkin  in  1  controller clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request strobe; accepted when req_valid && req_ready
req_psda  in  4  target phase step
req_dutyda  in  4  target duty code
req_fdly  in  4  target fine delay
req_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse at end of request
err  out  1  qualifies done: 1 = lock timeout; sticky copy in err_sticky
err_sticky  out  1  set on any timeout; cleared only by reset or by accepting a new request
busy  out  1  high in every state except IDLE
pll_lock  in  1  PLL lock, asynchronous to clkin
psda  out  4  to PLL psda
dutyda  out  4  to PLL dutyda
fdly  out  4  to PLL fdly

Behaviour:
- Reset values: psda=PSDA_INIT, dutyda=DUTY_INIT, fdly=FDLY_INIT, req_ready=1, done=0, err=0, err_sticky=0, busy=0, state=IDLE, counters=0, sync flops=0.
- pll_lock passes through a 2-FF synchronizer; lock_s is the second stage. All lock decisions use lock_s only.
- All outputs are registered. psda, dutyda and fdly change only on a STEP cycle.
- IDLE: on accept, latch the targets, clear err_sticky, then go to STEP. No other transitions.
- STEP (1 cycle):
  - dutyda<=target duty and fdly<=target fdly. This is idempotent after the first STEP.
  - If psda!=target, psda moves ±1 mod 16 along the shortest circular path. Distance 8 steps up (+1).
  - If psda==target on entry, psda is unchanged. Exactly one settle/lock check is still performed.
  - Next state: SETTLE with cnt=0.
- SETTLE: count SETTLE_CYCLES cycles, ignoring lock, then go to WAIT_LOCK with stable=0 and tmo=0.
- WAIT_LOCK: each cycle tmo++.
  - stable increments while lock_s=1 and resets to 0 when lock_s=0.
  - When stable reaches LOCK_STABLE:
    - If psda==target, go to DONE.
    - Otherwise, go to STEP.
  - If tmo reaches LOCK_TIMEOUT first, go to ERR. If both happen on the same cycle, lock success wins.
- DONE (1 cycle): done=1, err=0, then IDLE.
- ERR (1 cycle): done=1, err=1, err_sticky<=1, then IDLE.
  - Outputs are left at the last stepped value; there is no rollback.
- Latency for a request at circular distance d (d>=1) with lock held high: d*(1+SETTLE_CYCLES+LOCK_STABLE)+1 cycles from accept to done.
  - For d=0 the latency is that of d=1.
- req_valid outside IDLE is ignored; there is no queue. Request data is sampled only at acceptance.
- Asynchronous reset mid-operation forces every output to its reset value immediately. Any request in flight is dropped, with no done pulse.
- Counter widths: $clog2(param+1).

Decomposition:
- Shared package pll_dpa_pkg: state enum (IDLE, STEP, SETTLE, WAIT_LOCK, DONE, ERR), the PSDA/DUTY/FDLY width constant (4), and a function computing the step direction (shortest circular path, tie goes up).
- One sub-module: dpa_lock_sync. It contains the 2-FF synchronizer plus the stability counter, and outputs lock_s and lock_stable.

Test Plan:
1. Reset release with lock=1 -> psda=0, dutyda=8, fdly=0, req_ready=1, no done pulse within 100 cycles.
2. Request psda=3, duty=8, fdly=0, lock held high, SETTLE=16, STABLE=8 -> psda sequence is 1,2,3, each change 25 cycles apart; done=1, err=0 exactly 76 cycles after accept.
3. psda at 1, request psda=14 -> wraps downward 0,15,14 (3 steps). Then from 0 request 8 -> steps up through 1..8.
4. Request equal to current psda but duty=6, fdly=5 -> dutyda/fdly update on the first STEP cycle, psda unchanged, done after 26 cycles.
5. lock dropped after the first step and held low -> after LOCK_TIMEOUT cycles: done=1, err=1, err_sticky=1, psda frozen at 1. A following good request clears err_sticky on accept.
6. Lock glitches low for 1 cycle mid-WAIT_LOCK -> stability counter restarts and the step completes only after 8 fresh high cycles. Assert reset during SETTLE -> outputs return to init and no done pulse occurs.

Source files
------------

// File: rtl/pll_dpa_pkg.sv
// Shared types and helpers for the DDR PLL dynamic-phase controller.
// Holds the controller state encoding, the control-word width and the step-direction rule.
package pll_dpa_pkg;

  localparam int DPA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    WAIT_LOCK,
    DONE,
    ERR
  } dpa_state_t;

  // Shortest circular path modulo 16; a half-turn distance resolves upward.
  function automatic logic step_up(input logic [DPA_W-1:0] cur,
                                   input logic [DPA_W-1:0] tgt);
    logic [DPA_W-1:0] diff;
    diff = tgt - cur;
    return (diff <= DPA_W'(8));
  endfunction

endpackage

// File: rtl/dpa_lock_sync.sv
// Two-flop synchronizer for the PLL lock plus a run-length counter of consecutive high samples.
// The counter only runs while en is high and restarts from zero otherwise.
module dpa_lock_sync #(
  parameter int LOCK_STABLE = 8
) (
  input  logic clkin,
  input  logic reset,
  input  logic pll_lock,
  input  logic en,
  output logic lock_s,
  output logic lock_stable
);

  localparam int STABLE_W = $clog2(LOCK_STABLE + 1);

  logic                sync_p0;
  logic [STABLE_W-1:0] stable;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
      stable  <= '0;
    end else begin
      sync_p0 <= pll_lock;
      lock_s  <= sync_p0;
      if (!en || !lock_s)
        stable <= '0;
      else
        stable <= stable + STABLE_W'(1);
    end
  end

  // High when one more high lock_s sample completes the required run.
  assign lock_stable = (stable == STABLE_W'(LOCK_STABLE - 1));

endmodule

// File: rtl/pll_dpa_ctrl.sv
// Runtime controller walking the PLL psda one step at a time toward a requested phase,
// settling and confirming lock after every step before reporting done or a lock timeout.
module pll_dpa_ctrl
  import pll_dpa_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 16,
  parameter int               LOCK_STABLE   = 8,
  parameter int               LOCK_TIMEOUT  = 4096,
  parameter logic [DPA_W-1:0] PSDA_INIT     = 4'h0,
  parameter logic [DPA_W-1:0] DUTY_INIT     = 4'h8,
  parameter logic [DPA_W-1:0] FDLY_INIT     = 4'h0
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [DPA_W-1:0] req_psda,
  input  logic [DPA_W-1:0] req_dutyda,
  input  logic [DPA_W-1:0] req_fdly,
  output logic             req_ready,
  output logic             done,
  output logic             err,
  output logic             err_sticky,
  output logic             busy,
  input  logic             pll_lock,
  output logic [DPA_W-1:0] psda,
  output logic [DPA_W-1:0] dutyda,
  output logic [DPA_W-1:0] fdly
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);

  dpa_state_t          state;
  logic [DPA_W-1:0]    tgt_psda;
  logic [DPA_W-1:0]    tgt_duty;
  logic [DPA_W-1:0]    tgt_fdly;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                lock_s;
  logic                lock_stable;

  dpa_lock_sync #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_sync (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .en         (state == WAIT_LOCK),
    .lock_s     (lock_s),
    .lock_stable(lock_stable)
  );

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      psda       <= PSDA_INIT;
      dutyda     <= DUTY_INIT;
      fdly       <= FDLY_INIT;
      tgt_psda   <= '0;
      tgt_duty   <= '0;
      tgt_fdly   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            tgt_psda   <= req_psda;
            tgt_duty   <= req_dutyda;
            tgt_fdly   <= req_fdly;
            err_sticky <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= STEP;
          end
        end
        STEP: begin
          dutyda <= tgt_duty;
          fdly   <= tgt_fdly;
          if (psda != tgt_psda)
            psda <= step_up(psda, tgt_psda) ? psda + DPA_W'(1) : psda - DPA_W'(1);
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            tmo_cnt <= '0;
            state   <= WAIT_LOCK;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        WAIT_LOCK: begin
          // A stable lock on the final timeout cycle still counts as success.
          if (lock_s && lock_stable)
            state <= (psda == tgt_psda) ? DONE : STEP;
          else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1))
            state <= ERR;
          else
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        DONE: begin
          done      <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        ERR: begin
          done       <= 1'b1;
          err        <= 1'b1;
          err_sticky <= 1'b1;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dpa_ctrl.sv
// Directed bench for pll_dpa_ctrl: reset state, stepping, wrap-around, lock glitch,
// lock timeout and reset in the middle of a request.
module tb_pll_dpa_ctrl;

  logic       clkin = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_psda, req_dutyda, req_fdly;
  logic       req_ready, done, err, err_sticky, busy;
  logic       pll_lock;
  logic [3:0] psda, dutyda, fdly;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] tr_val [0:15];
  int         tr_cyc [0:15];
  int         tr_n;
  int         lat;
  logic       err_done, sticky_done, sticky_n0, busy_n0, ready_n0;
  logic [3:0] duty_n1, fdly_n1;

  always #5 clkin = ~clkin;

  pll_dpa_ctrl dut (
    .clkin     (clkin),
    .reset     (reset),
    .req_valid (req_valid),
    .req_psda  (req_psda),
    .req_dutyda(req_dutyda),
    .req_fdly  (req_fdly),
    .req_ready (req_ready),
    .done      (done),
    .err       (err),
    .err_sticky(err_sticky),
    .busy      (busy),
    .pll_lock  (pll_lock),
    .psda      (psda),
    .dutyda    (dutyda),
    .fdly      (fdly)
  );

  // Issues one request and records psda changes, cycle stamps and the done latency.
  // pll_lock is driven low at cycle low_from and high again at low_to (-1 = never).
  task automatic do_req(input logic [3:0] p, input logic [3:0] d, input logic [3:0] f,
                        input int low_from, input int low_to, input int budget);
    logic [3:0] prev;
    tr_n = 0;
    lat  = -1;
    err_done = 1'bx;
    sticky_done = 1'bx;
    @(negedge clkin);
    req_psda = p; req_dutyda = d; req_fdly = f; req_valid = 1'b1;
    @(posedge clkin); #1;
    req_valid = 1'b0;
    ready_n0 = req_ready; busy_n0 = busy; sticky_n0 = err_sticky;
    prev = psda;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clkin); #1;
      if (n == low_from) pll_lock = 1'b0;
      if (n == low_to) pll_lock = 1'b1;
      if (n == 1) begin duty_n1 = dutyda; fdly_n1 = fdly; end
      if (psda !== prev) begin
        if (tr_n < 16) begin tr_val[tr_n] = psda; tr_cyc[tr_n] = n; end
        tr_n++;
        prev = psda;
      end
      if (done === 1'b1) begin
        lat = n; err_done = err; sticky_done = err_sticky;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic seen;
    reset = 1'b1; pll_lock = 1'b1; req_valid = 1'b0;
    req_psda = '0; req_dutyda = '0; req_fdly = '0;
    repeat (3) @(posedge clkin);
    @(negedge clkin); reset = 1'b0;
    #1;
    n_checks++; if (psda !== 4'h0) begin n_fail++; $display("FAIL reset_psda got %0h need 0", psda); end
    n_checks++; if (dutyda !== 4'h8) begin n_fail++; $display("FAIL reset_dutyda got %0h need 8", dutyda); end
    n_checks++; if (fdly !== 4'h0) begin n_fail++; $display("FAIL reset_fdly got %0h need 0", fdly); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b need 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b need 0", busy); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b need 0", err_sticky); end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clkin); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_done got %b need 0", seen); end
  endtask

  task automatic test_walk_up;
    do_req(4'd3, 4'd8, 4'd0, -1, -1, 300);
    n_checks++; if (ready_n0 !== 1'b0) begin n_fail++; $display("FAIL walk_ready_busy got %b need 0", ready_n0); end
    n_checks++; if (busy_n0 !== 1'b1) begin n_fail++; $display("FAIL walk_busy got %b need 1", busy_n0); end
    n_checks++; if (tr_n !== 3) begin n_fail++; $display("FAIL walk_nsteps got %0d need 3", tr_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tr_val[i] !== 4'(i + 1) || tr_cyc[i] !== 1 + 25 * i) begin
        n_fail++;
        $display("FAIL walk_step%0d got %0h@%0d need %0h@%0d", i, tr_val[i], tr_cyc[i], i + 1, 1 + 25 * i);
      end
    end
    n_checks++; if (lat !== 76) begin n_fail++; $display("FAIL walk_latency got %0d need 76", lat); end
    n_checks++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL walk_err got %b need 0", err_done); end
    @(posedge clkin); #1;
    n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL walk_after got done=%b ready=%b need 0/1", done, req_ready);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] e2a [2] = '{4'h2, 4'h1};
    logic [3:0] e3  [3] = '{4'h0, 4'hF, 4'hE};
    logic [3:0] e2b [2] = '{4'hF, 4'h0};
    do_req(4'd1, 4'd8, 4'd0, -1, -1, 300);
    n_checks++; if (tr_n !== 2 || tr_val[0] !== e2a[0] || tr_val[1] !== e2a[1] || lat !== 51) begin
      n_fail++; $display("FAIL wrap_3to1 got n=%0d %0h,%0h lat=%0d need 2 2,1 51", tr_n, tr_val[0], tr_val[1], lat);
    end
    do_req(4'd14, 4'd8, 4'd0, -1, -1, 300);
    n_checks++; if (tr_n !== 3) begin n_fail++; $display("FAIL wrap_down_n got %0d need 3", tr_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (tr_val[i] !== e3[i]) begin
        n_fail++; $display("FAIL wrap_down%0d got %0h need %0h", i, tr_val[i], e3[i]);
      end
    end
    n_checks++; if (lat !== 76) begin n_fail++; $display("FAIL wrap_down_lat got %0d need 76", lat); end
    do_req(4'd0, 4'd8, 4'd0, -1, -1, 300);
    n_checks++; if (tr_n !== 2 || tr_val[0] !== e2b[0] || tr_val[1] !== e2b[1]) begin
      n_fail++; $display("FAIL wrap_up14to0 got n=%0d %0h,%0h need 2 f,0", tr_n, tr_val[0], tr_val[1]);
    end
    do_req(4'd8, 4'd8, 4'd0, -1, -1, 400);
    n_checks++; if (tr_n !== 8) begin n_fail++; $display("FAIL half_turn_n got %0d need 8", tr_n); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tr_val[i] !== 4'(i + 1) || tr_cyc[i] !== 1 + 25 * i) begin
        n_fail++;
        $display("FAIL half_turn%0d got %0h@%0d need %0h@%0d", i, tr_val[i], tr_cyc[i], i + 1, 1 + 25 * i);
      end
    end
    n_checks++; if (lat !== 201) begin n_fail++; $display("FAIL half_turn_lat got %0d need 201", lat); end
  endtask

  task automatic test_same_target;
    do_req(4'd8, 4'd6, 4'd5, -1, -1, 300);
    n_checks++; if (duty_n1 !== 4'd6 || fdly_n1 !== 4'd5) begin
      n_fail++; $display("FAIL same_duty_fdly got %0h/%0h need 6/5", duty_n1, fdly_n1);
    end
    n_checks++; if (tr_n !== 0 || psda !== 4'd8) begin
      n_fail++; $display("FAIL same_psda got n=%0d psda=%0h need 0 8", tr_n, psda);
    end
    n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL same_latency got %0d need 26", lat); end
  endtask

  task automatic test_lock_glitch;
    do_req(4'd9, 4'd6, 4'd5, 20, 21, 300);
    n_checks++; if (tr_n !== 1 || tr_val[0] !== 4'd9) begin
      n_fail++; $display("FAIL glitch_step got n=%0d %0h need 1 9", tr_n, tr_val[0]);
    end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL glitch_latency got %0d need 32", lat); end
    n_checks++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL glitch_err got %b need 0", err_done); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clkin);
    req_psda = 4'd12; req_dutyda = 4'd3; req_fdly = 4'd7; req_valid = 1'b1;
    @(posedge clkin); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clkin);
    #1;
    n_checks++; if (psda !== 4'd10 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got psda=%0h busy=%b need a/1", psda, busy);
    end
    reset = 1'b1;
    #1;
    n_checks++; if (psda !== 4'h0 || dutyda !== 4'h8 || fdly !== 4'h0) begin
      n_fail++; $display("FAIL mid_outputs got %0h/%0h/%0h need 0/8/0", psda, dutyda, fdly);
    end
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_ctrl got ready=%b busy=%b done=%b need 1/0/0", req_ready, busy, done);
    end
    @(negedge clkin); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clkin); #1;
      if (done !== 1'b0 || psda !== 4'h0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_quiet got %b need 0", seen); end
  endtask

  task automatic test_timeout;
    do_req(4'd3, 4'd8, 4'd0, 1, -1, 5000);
    n_checks++; if (lat !== 4114) begin n_fail++; $display("FAIL tmo_latency got %0d need 4114", lat); end
    n_checks++; if (err_done !== 1'b1 || sticky_done !== 1'b1) begin
      n_fail++; $display("FAIL tmo_err got err=%b sticky=%b need 1/1", err_done, sticky_done);
    end
    n_checks++; if (psda !== 4'd1 || tr_n !== 1) begin
      n_fail++; $display("FAIL tmo_frozen got psda=%0h n=%0d need 1 1", psda, tr_n);
    end
    pll_lock = 1'b1;
    repeat (5) @(posedge clkin);
    #1;
    n_checks++; if (err_sticky !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_sticky_hold got sticky=%b err=%b need 1/0", err_sticky, err);
    end
    do_req(4'd1, 4'd8, 4'd0, -1, -1, 300);
    n_checks++; if (sticky_n0 !== 1'b0) begin n_fail++; $display("FAIL tmo_clear_on_accept got %b need 0", sticky_n0); end
    n_checks++; if (lat !== 26 || err_done !== 1'b0) begin
      n_fail++; $display("FAIL tmo_recover got lat=%0d err=%b need 26/0", lat, err_done);
    end
  endtask

  initial begin
    test_reset;
    test_walk_up;
    test_wrap;
    test_same_target;
    test_lock_glitch;
    test_reset_mid;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
